aes_stream_ctrl: RTL and testbench
==================================

// Module: aes_stream_ctrl
// PURPOSE
// Host-side initiator for the Aes core: drives its key/data/enable inputs and consumes
// o_Dout/o_Dout_En. Packs a 32-bit word stream into 128-bit blocks and loads 128/192/256-bit keys.
// Unpacks each result into a 32-bit output stream with valid/ready backpressure.
// Sits between a bus-side FIFO and one Aes instance; no chaining modes (ECB only).
// PARAMETERS
// KEY_WAIT   8    cycles after o_Aes_Key_En before data may issue (key expansion)
// WAIT_MAX   16   max cycles from o_Aes_Din_En to i_Aes_Dout_En before timeout
// PORTS
// i_Clk          in   1    clock, all logic on rising edge
// i_Rst          in   1    reset, synchronous, active-high
// i_Start        in   1    pulse: latch i_Key_Mode/i_Mode, begin key load
// i_Key_Mode     in   2    0:AES-128 1:AES-192 2:AES-256 (3 treated as 2)
// i_Mode         in   1    0:encrypt 1:decrypt
// i_Word         in   32   input word (key words, then data words)
// i_Word_Valid   in   1    input word valid
// o_Word_Ready   out  1    input word accepted when Valid&Ready
// o_Word         out  32   result word
// o_Word_Valid   out  1    result word valid; held with o_Word stable until i_Word_Ready
// i_Word_Ready   in   1    downstream ready
// o_Key_Ready    out  1    key expanded, data path open
// o_Err          out  1    one-cycle pulse on core timeout
// o_Aes_En, o_Aes_Key_Mode[1:0], o_Aes_Mode, o_Aes_Key[255:0], o_Aes_Key_En,
// o_Aes_Din[127:0], o_Aes_Din_En   out  -> Aes i_* ports of same name
// i_Aes_Dout[127:0], i_Aes_Dout_En in  <- Aes o_Dout/o_Dout_En
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0; latched config 0. Reset mid-block discards all.
// - States: IDLE -> KEY_LOAD -> KEY_WAIT -> READY -> BLK_LOAD -> BLK_WAIT -> BLK_OUT -> READY.
// - IDLE: o_Word_Ready=0. i_Start -> KEY_LOAD; clear o_Aes_Key, key word count.
// - KEY_LOAD: o_Word_Ready=1; accepts Nk=4/6/8 words MSB-first into o_Aes_Key[255:224] downward;
//   unused low bits stay 0. After last word: o_Aes_Key_En=1 for exactly one cycle -> KEY_WAIT.
// - KEY_WAIT: count KEY_WAIT cycles, then o_Key_Ready=1 (stays 1 until i_Start/reset) -> READY.
// - o_Aes_En=1 in every state except IDLE; o_Aes_Key_Mode/o_Aes_Mode = latched config, constant.
// - READY/BLK_LOAD: o_Word_Ready=1; 4 words packed MSB-first (first word -> [127:96]).
//   On 4th accept: o_Aes_Din registered, o_Aes_Din_En=1 next cycle for one cycle -> BLK_WAIT.
// - BLK_WAIT: o_Word_Ready=0; cycle counter from Din_En. i_Aes_Dout_En=1 -> capture i_Aes_Dout,
//   -> BLK_OUT. Counter reaching WAIT_MAX without Dout_En -> o_Err pulse, drop block, -> READY.
// - BLK_OUT: emit 4 words MSB-first; advance only on o_Word_Valid&i_Word_Ready; after 4th -> READY.
//   Min word throughput 1/cycle; stall indefinitely under backpressure, no data loss.
// - i_Aes_Dout_En outside BLK_WAIT: ignored.
// - i_Start in any non-IDLE state: abort (partial block/result discarded, o_Word_Valid drops
//   same edge), o_Key_Ready=0, go KEY_LOAD. i_Start wins over a same-cycle word accept.
// - i_Start and i_Word_Valid same cycle in IDLE: word not accepted (Ready=0 that cycle).
// - Word counters 2-bit/3-bit, wrap to 0 on state exit; no partial-block flush.
// STRUCTURE
// - Package aes_stream_pkg: state enum, NK_WORDS(key_mode) function, word/block width consts.
// - One sub-module aes_word_unpacker: 128-bit load, 32-bit valid/ready shift-out (BLK_OUT).
// - Key/data packers are inline shift registers in this module.
// TESTING
// - Reset: assert i_Rst 2 cycles mid-BLK_OUT -> all outputs 0, state IDLE, o_Key_Ready=0.
// - AES-128 enc with real Aes: key 000102..0f, pt 00112233445566778899aabbccddeeff
//   -> words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
// - AES-256 dec: key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> 00112233..eeff.
// - Backpressure: i_Word_Ready toggling 1/0 each cycle -> same 4 words, order kept, no dups.
// - Timeout: stub core never asserts Dout_En -> o_Err pulse exactly WAIT_MAX cycles after Din_En.
// - Restart: i_Start during BLK_WAIT -> o_Key_Ready=0, new key accepted, next block correct.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES word-stream controller.
package aes_stream_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int KEY_W     = 256;
  localparam int BLK_WORDS = BLOCK_W / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_LOAD,
    ST_KEY_WAIT,
    ST_READY,
    ST_BLK_LOAD,
    ST_BLK_WAIT,
    ST_BLK_OUT
  } state_t;

  // Number of 32-bit key words for a key mode; mode 3 behaves as AES-256.
  function automatic int nk_words(input logic [1:0] key_mode);
    int n;
    case (key_mode)
      2'd0:    n = 4;
      2'd1:    n = 6;
      default: n = 8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds one 128-bit result and shifts it out as four 32-bit words, MSB word first,
// under valid/ready flow control. The word on the output is held until taken.
module aes_word_unpacker
  import aes_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block,
  input  logic               ready,
  output logic [WORD_W-1:0]  word,
  output logic               valid,
  output logic               done
);

  logic [BLOCK_W-1:0] shreg;
  logic [1:0]         cnt;

  assign word = shreg[BLOCK_W-1 -: WORD_W];
  assign done = valid & ready & (cnt == 2'd3);

  // Load a block, then advance one word per accepted handshake; abort clears it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shreg <= '0;
      cnt   <= 2'd0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= block;
      cnt   <= 2'd0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (cnt == 2'd3) begin
        valid <= 1'b0;
      end else begin
        shreg <= {shreg[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      end
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Word-stream front end for one ECB AES core: packs 32-bit words into a key and
// 128-bit blocks, waits out key expansion, times each block, and streams results out.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int KEY_WAIT = 8,
  parameter int WAIT_MAX = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [1:0]         i_Key_Mode,
  input  logic               i_Mode,
  input  logic [WORD_W-1:0]  i_Word,
  input  logic               i_Word_Valid,
  output logic               o_Word_Ready,
  output logic [WORD_W-1:0]  o_Word,
  output logic               o_Word_Valid,
  input  logic               i_Word_Ready,
  output logic               o_Key_Ready,
  output logic               o_Err,
  output logic               o_Aes_En,
  output logic [1:0]         o_Aes_Key_Mode,
  output logic               o_Aes_Mode,
  output logic [KEY_W-1:0]   o_Aes_Key,
  output logic               o_Aes_Key_En,
  output logic [BLOCK_W-1:0] o_Aes_Din,
  output logic               o_Aes_Din_En,
  input  logic [BLOCK_W-1:0] i_Aes_Dout,
  input  logic               i_Aes_Dout_En
);

  localparam int CNT_MAX = (KEY_WAIT > WAIT_MAX) ? KEY_WAIT : WAIT_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [2:0]       key_cnt;
  logic [1:0]       blk_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             unpack_load;
  logic             unpack_done;

  // A restart request takes priority over any word offered in the same cycle.
  assign accept      = i_Word_Valid & o_Word_Ready & ~i_Start;
  assign unpack_load = (state == ST_BLK_WAIT) & i_Aes_Dout_En & ~i_Start;

  aes_word_unpacker u_unpacker (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .flush (i_Start),
    .load  (unpack_load),
    .block (i_Aes_Dout),
    .ready (i_Word_Ready),
    .word  (o_Word),
    .valid (o_Word_Valid),
    .done  (unpack_done)
  );

  // Main sequencer: key load, expansion wait, block packing, core timeout, result drain.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state          <= ST_IDLE;
      key_cnt        <= 3'd0;
      blk_cnt        <= 2'd0;
      wait_cnt       <= '0;
      o_Word_Ready   <= 1'b0;
      o_Key_Ready    <= 1'b0;
      o_Err          <= 1'b0;
      o_Aes_En       <= 1'b0;
      o_Aes_Key_Mode <= 2'd0;
      o_Aes_Mode     <= 1'b0;
      o_Aes_Key      <= '0;
      o_Aes_Key_En   <= 1'b0;
      o_Aes_Din      <= '0;
      o_Aes_Din_En   <= 1'b0;
    end else begin
      o_Aes_Key_En <= 1'b0;
      o_Aes_Din_En <= 1'b0;
      o_Err        <= 1'b0;
      if (i_Start) begin
        state          <= ST_KEY_LOAD;
        o_Aes_En       <= 1'b1;
        o_Aes_Key_Mode <= (i_Key_Mode == 2'd3) ? 2'd2 : i_Key_Mode;
        o_Aes_Mode     <= i_Mode;
        o_Aes_Key      <= '0;
        key_cnt        <= 3'd0;
        blk_cnt        <= 2'd0;
        wait_cnt       <= '0;
        o_Word_Ready   <= 1'b1;
        o_Key_Ready    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            o_Word_Ready <= 1'b0;
          end
          ST_KEY_LOAD: begin
            if (accept) begin
              o_Aes_Key[KEY_W-1 - WORD_W*int'(key_cnt) -: WORD_W] <= i_Word;
              if (int'(key_cnt) == nk_words(o_Aes_Key_Mode) - 1) begin
                key_cnt      <= 3'd0;
                o_Aes_Key_En <= 1'b1;
                o_Word_Ready <= 1'b0;
                wait_cnt     <= '0;
                state        <= ST_KEY_WAIT;
              end else begin
                key_cnt <= key_cnt + 3'd1;
              end
            end
          end
          ST_KEY_WAIT: begin
            if (wait_cnt == CNT_W'(KEY_WAIT - 1)) begin
              wait_cnt     <= '0;
              o_Key_Ready  <= 1'b1;
              o_Word_Ready <= 1'b1;
              state        <= ST_READY;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          ST_READY, ST_BLK_LOAD: begin
            if (accept) begin
              o_Aes_Din[BLOCK_W-1 - WORD_W*int'(blk_cnt) -: WORD_W] <= i_Word;
              if (blk_cnt == 2'(BLK_WORDS - 1)) begin
                blk_cnt      <= 2'd0;
                o_Aes_Din_En <= 1'b1;
                o_Word_Ready <= 1'b0;
                wait_cnt     <= '0;
                state        <= ST_BLK_WAIT;
              end else begin
                blk_cnt <= blk_cnt + 2'd1;
                state   <= ST_BLK_LOAD;
              end
            end
          end
          ST_BLK_WAIT: begin
            if (i_Aes_Dout_En) begin
              wait_cnt <= '0;
              state    <= ST_BLK_OUT;
            end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
              wait_cnt     <= '0;
              o_Err        <= 1'b1;
              o_Word_Ready <= 1'b1;
              state        <= ST_READY;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          ST_BLK_OUT: begin
            if (unpack_done) begin
              o_Word_Ready <= 1'b1;
              state        <= ST_READY;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl with a behavioural stand-in for the AES core.
module tb_aes_stream_ctrl;

  localparam int KEY_WAIT = 8;
  localparam int WAIT_MAX = 16;
  localparam int CORE_LAT = 3;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KR    = 256'h13579bdf2468ace0fedcba9876543210a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] B2    = 128'hdeadbeef0123456789abcdefcafef00d;

  logic         clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_Start = 1'b0;
  logic [1:0]   i_Key_Mode = 2'd0;
  logic         i_Mode = 1'b0;
  logic [31:0]  i_Word = 32'd0;
  logic         i_Word_Valid = 1'b0;
  logic         o_Word_Ready;
  logic [31:0]  o_Word;
  logic         o_Word_Valid;
  logic         i_Word_Ready = 1'b1;
  logic         o_Key_Ready;
  logic         o_Err;
  logic         o_Aes_En;
  logic [1:0]   o_Aes_Key_Mode;
  logic         o_Aes_Mode;
  logic [255:0] o_Aes_Key;
  logic         o_Aes_Key_En;
  logic [127:0] o_Aes_Din;
  logic         o_Aes_Din_En;
  logic [127:0] core_dout = '0;
  logic         core_dout_en = 1'b0;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];
  bit core_respond = 1'b1;
  bit err_ok = 1'b0;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.KEY_WAIT(KEY_WAIT), .WAIT_MAX(WAIT_MAX)) dut (
    .i_Clk          (clk),
    .i_Rst          (i_Rst),
    .i_Start        (i_Start),
    .i_Key_Mode     (i_Key_Mode),
    .i_Mode         (i_Mode),
    .i_Word         (i_Word),
    .i_Word_Valid   (i_Word_Valid),
    .o_Word_Ready   (o_Word_Ready),
    .o_Word         (o_Word),
    .o_Word_Valid   (o_Word_Valid),
    .i_Word_Ready   (i_Word_Ready),
    .o_Key_Ready    (o_Key_Ready),
    .o_Err          (o_Err),
    .o_Aes_En       (o_Aes_En),
    .o_Aes_Key_Mode (o_Aes_Key_Mode),
    .o_Aes_Mode     (o_Aes_Mode),
    .o_Aes_Key      (o_Aes_Key),
    .o_Aes_Key_En   (o_Aes_Key_En),
    .o_Aes_Din      (o_Aes_Din),
    .o_Aes_Din_En   (o_Aes_Din_En),
    .i_Aes_Dout     (core_dout),
    .i_Aes_Dout_En  (core_dout_en)
  );

  // Core stand-in: known FIPS-197 vectors, otherwise din XOR upper key half.
  function automatic logic [127:0] core_func(input logic [255:0] k, input logic [1:0] km,
                                             input logic m, input logic [127:0] d);
    if (km == 2'd0 && !m && k == K128 && d == PT) return CT128;
    if (km == 2'd2 && m && k == K256 && d == CT256) return PT;
    return d ^ k[255:128];
  endfunction

  logic [255:0] core_key = '0;
  logic [1:0]   core_km = 2'd0;
  logic         core_m = 1'b0;
  logic [127:0] core_din = '0;
  logic         core_busy = 1'b0;
  int           core_cnt = 0;

  always @(posedge clk) begin
    core_dout_en <= 1'b0;
    if (i_Rst) begin
      core_busy <= 1'b0;
    end else begin
      if (o_Aes_Key_En) begin
        core_key <= o_Aes_Key;
        core_km  <= o_Aes_Key_Mode;
        core_m   <= o_Aes_Mode;
      end
      if (o_Aes_Din_En && core_respond) begin
        core_busy <= 1'b1;
        core_cnt  <= CORE_LAT;
        core_din  <= o_Aes_Din;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy    <= 1'b0;
          core_dout_en <= 1'b1;
          core_dout    <= core_func(core_key, core_km, core_m, core_din);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: every word handed downstream must be the next expected one.
  always @(negedge clk) begin
    if (!i_Rst) begin
      if (o_Word_Valid && i_Word_Ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL out_word unexpected: got %h, none expected", o_Word);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (o_Word !== e) begin
            failed++;
            $display("FAIL out_word: got %h, want %h", o_Word, e);
          end
        end
      end
      if (o_Err && !err_ok) begin
        tests++;
        failed++;
        $display("FAIL spurious_err: got o_Err=1, want 0");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[127-32*i -: 32]);
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    i_Word = w;
    i_Word_Valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (o_Word_Ready) ok = 1'b1;
      tick(1);
    end
    i_Word_Valid = 1'b0;
  endtask

  task automatic send_key(input logic [255:0] k, input int n, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(k[255-32*i -: 32], o);
      ok &= o;
    end
  endtask

  task automatic send_block(input logic [127:0] b, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(b[127-32*i -: 32], o);
      ok &= o;
    end
  endtask

  task automatic do_start(input logic [1:0] km, input logic m);
    i_Start = 1'b1;
    i_Key_Mode = km;
    i_Mode = m;
    tick(1);
    i_Start = 1'b0;
  endtask

  task automatic wait_key_ready(output int n);
    n = 0;
    while (!o_Key_Ready && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_drain(input int budget, output int left);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    left = exp_q.size();
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    i_Rst = 1'b1;
    tick(2);
    ctl = {o_Word_Ready, o_Word_Valid, o_Key_Ready, o_Err, o_Aes_En, o_Aes_Key_En, o_Aes_Din_En, o_Aes_Mode};
    tests++;
    if (ctl !== 8'h00 || o_Aes_Key_Mode !== 2'd0) begin
      failed++;
      $display("FAIL reset_ctl: got %b/%0d, want 00000000/0", ctl, o_Aes_Key_Mode);
    end
    tests++;
    if (o_Aes_Key !== '0 || o_Aes_Din !== '0 || o_Word !== 32'd0) begin
      failed++;
      $display("FAIL reset_data: got key=%h din=%h word=%h, want all 0", o_Aes_Key, o_Aes_Din, o_Word);
    end
    i_Rst = 1'b0;
    i_Word_Valid = 1'b1;
    tick(2);
    i_Word_Valid = 1'b0;
    tests++;
    if (o_Word_Ready !== 1'b0 || o_Aes_En !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_reset: got ready=%b en=%b, want 0 0", o_Word_Ready, o_Aes_En);
    end
  endtask

  task automatic test_aes128_enc();
    bit ok;
    int n;
    int left;
    do_start(2'd0, 1'b0);
    send_key(K128, 4, ok);
    tests++;
    if (!ok || o_Aes_Key_En !== 1'b1 || o_Aes_Key !== K128) begin
      failed++;
      $display("FAIL key128_load: got ok=%b key_en=%b key=%h, want 1 1 %h", ok, o_Aes_Key_En, o_Aes_Key, K128);
    end
    wait_key_ready(n);
    tests++;
    if (n != KEY_WAIT) begin
      failed++;
      $display("FAIL key_wait_cycles: got %0d, want %0d", n, KEY_WAIT);
    end
    tests++;
    if (o_Aes_En !== 1'b1 || o_Aes_Key_Mode !== 2'd0 || o_Aes_Mode !== 1'b0 || o_Word_Ready !== 1'b1) begin
      failed++;
      $display("FAIL cfg128: got en=%b km=%0d m=%b rdy=%b, want 1 0 0 1", o_Aes_En, o_Aes_Key_Mode, o_Aes_Mode, o_Word_Ready);
    end
    push_block(CT128);
    send_block(PT, ok);
    tests++;
    if (!ok || o_Aes_Din_En !== 1'b1 || o_Aes_Din !== PT) begin
      failed++;
      $display("FAIL din128: got ok=%b din_en=%b din=%h, want 1 1 %h", ok, o_Aes_Din_En, o_Aes_Din, PT);
    end
    wait_drain(100, left);
    tests++;
    if (left != 0) begin
      failed++;
      $display("FAIL enc128_drain: got %0d words left, want 0", left);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stall;
    logic [31:0] held;
    i_Word_Ready = 1'b0;
    push_block(CT128);
    send_block(PT, ok);
    stall = 1'b0;
    held = '0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      if (stall) begin
        tests++;
        if (o_Word_Valid !== 1'b1 || o_Word !== held) begin
          failed++;
          $display("FAIL bp_hold: got valid=%b word=%h, want 1 %h", o_Word_Valid, o_Word, held);
        end
      end
      i_Word_Ready = (i % 2 == 0);
      stall = o_Word_Valid && !i_Word_Ready;
      held = o_Word;
      tick(1);
    end
    i_Word_Ready = 1'b1;
    tests++;
    if (!ok || exp_q.size() != 0) begin
      failed++;
      $display("FAIL bp_drain: got ok=%b left=%0d, want 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok1;
    bit ok2;
    int left;
    push_block(CT128);
    push_block(B2 ^ K128[255:128]);
    send_block(PT, ok1);
    send_block(B2, ok2);
    wait_drain(100, left);
    tests++;
    if (!ok1 || !ok2 || left != 0) begin
      failed++;
      $display("FAIL back_to_back: got ok=%b%b left=%0d, want 11 0", ok1, ok2, left);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    core_respond = 1'b0;
    err_ok = 1'b1;
    send_block(B2, ok);
    n = 0;
    while (!o_Err && n < 40) begin
      tick(1);
      n++;
    end
    tests++;
    if (!ok || n != WAIT_MAX) begin
      failed++;
      $display("FAIL timeout_cycles: got ok=%b n=%0d, want 1 %0d", ok, n, WAIT_MAX);
    end
    tick(1);
    tests++;
    if (o_Err !== 1'b0 || o_Word_Ready !== 1'b1 || o_Word_Valid !== 1'b0) begin
      failed++;
      $display("FAIL timeout_after: got err=%b rdy=%b vld=%b, want 0 1 0", o_Err, o_Word_Ready, o_Word_Valid);
    end
    err_ok = 1'b0;
    core_respond = 1'b1;
  endtask

  task automatic test_aes256_dec();
    bit ok;
    int n;
    int left;
    i_Word = 32'hbad0bad0;
    i_Word_Valid = 1'b1;
    do_start(2'd2, 1'b1);
    i_Word_Valid = 1'b0;
    send_key(K256, 8, ok);
    tests++;
    if (!ok || o_Aes_Key_En !== 1'b1 || o_Aes_Key !== K256 || o_Word_Ready !== 1'b0) begin
      failed++;
      $display("FAIL key256_load: got ok=%b key_en=%b rdy=%b key=%h, want 1 1 0 %h", ok, o_Aes_Key_En, o_Word_Ready, o_Aes_Key, K256);
    end
    wait_key_ready(n);
    tests++;
    if (n != KEY_WAIT || o_Aes_Key_Mode !== 2'd2 || o_Aes_Mode !== 1'b1) begin
      failed++;
      $display("FAIL cfg256: got n=%0d km=%0d m=%b, want %0d 2 1", n, o_Aes_Key_Mode, o_Aes_Mode, KEY_WAIT);
    end
    push_block(PT);
    send_block(CT256, ok);
    wait_drain(100, left);
    tests++;
    if (!ok || left != 0) begin
      failed++;
      $display("FAIL dec256_drain: got ok=%b left=%0d, want 1 0", ok, left);
    end
  endtask

  task automatic test_restart();
    bit ok;
    int n;
    int left;
    send_block(B2, ok);
    do_start(2'd3, 1'b0);
    tests++;
    if (o_Key_Ready !== 1'b0 || o_Word_Ready !== 1'b1 || o_Aes_Key_Mode !== 2'd2 || o_Aes_Key !== '0) begin
      failed++;
      $display("FAIL restart_state: got kr=%b rdy=%b km=%0d, want 0 1 2 with key cleared", o_Key_Ready, o_Word_Ready, o_Aes_Key_Mode);
    end
    send_key(KR, 8, ok);
    tests++;
    if (!ok || o_Aes_Key !== KR || o_Word_Ready !== 1'b0) begin
      failed++;
      $display("FAIL restart_key: got ok=%b rdy=%b key=%h, want 1 0 %h", ok, o_Word_Ready, o_Aes_Key, KR);
    end
    wait_key_ready(n);
    push_block(PT ^ KR[255:128]);
    send_block(PT, ok);
    wait_drain(100, left);
    tick(6);
    tests++;
    if (!ok || n != KEY_WAIT || left != 0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL restart_block: got ok=%b n=%0d left=%0d, want 1 %0d 0", ok, n, left, KEY_WAIT);
    end
  endtask

  task automatic test_reset_mid_out();
    bit ok;
    int n;
    logic [7:0] ctl;
    i_Word_Ready = 1'b0;
    send_block(B2, ok);
    n = 0;
    while (!o_Word_Valid && n < 40) begin
      tick(1);
      n++;
    end
    tests++;
    if (!ok || o_Word_Valid !== 1'b1) begin
      failed++;
      $display("FAIL reach_blk_out: got ok=%b vld=%b, want 1 1", ok, o_Word_Valid);
    end
    i_Rst = 1'b1;
    tick(2);
    ctl = {o_Word_Ready, o_Word_Valid, o_Key_Ready, o_Err, o_Aes_En, o_Aes_Key_En, o_Aes_Din_En, o_Aes_Mode};
    tests++;
    if (ctl !== 8'h00 || o_Aes_Key !== '0 || o_Aes_Din !== '0 || o_Word !== 32'd0 || o_Aes_Key_Mode !== 2'd0) begin
      failed++;
      $display("FAIL reset_mid_out: got ctl=%b word=%h, want 00000000 and all data 0", ctl, o_Word);
    end
    i_Rst = 1'b0;
    i_Word_Ready = 1'b1;
    exp_q.delete();
    tick(3);
    tests++;
    if (o_Word_Ready !== 1'b0 || o_Word_Valid !== 1'b0 || o_Aes_En !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_mid_reset: got rdy=%b vld=%b en=%b, want 0 0 0", o_Word_Ready, o_Word_Valid, o_Aes_En);
    end
  endtask

  initial begin
    test_reset();
    test_aes128_enc();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_aes256_dec();
    test_restart();
    test_reset_mid_out();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
